// File: rtl/elastic_stream_src_if.sv
// Valid/ready stream bundle between a word source and an elastic stage.
//   o_data  : payload, driven by the initiator
//   o_valid : payload valid, driven by the initiator
//   o_ready : downstream ready, driven by the target
// master modport is the initiator side, slave modport the target side.
interface elastic_stream_src_if #(
    parameter int unsigned DW = 32
) ();
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;

    modport master (
        output o_data,
        output o_valid,
        input  o_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output o_ready
    );
endinterface

// File: rtl/elastic_stream_src.sv
// Programmable word source: emits cfg_count words base, base+step, ... on a
// valid/ready stream, optionally throttled by an LFSR-gated mask, and keeps
// per-job handshake and stall statistics.
//   clk, rst        : clock, synchronous active-high reset
//   cfg_start       : job start, honoured only while idle
//   cfg_count       : words in the job (0 gives an immediate done pulse)
//   cfg_base        : first payload value
//   cfg_step        : payload increment (wraps modulo 2^DW)
//   cfg_gap_mask    : valid throttle mask, 0 = full rate
//   strm            : stream initiator (o_data / o_valid / o_ready)
//   busy            : job running
//   done            : one-cycle completion pulse
//   sent_count      : handshakes in the current or last job
//   stall_count     : valid-without-ready cycles, saturating
module elastic_stream_src #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic [CW-1:0]       cfg_count,
    input  logic [DW-1:0]       cfg_base,
    input  logic [DW-1:0]       cfg_step,
    input  logic [3:0]          cfg_gap_mask,
    elastic_stream_src_if.master strm,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       sent_count,
    output logic [CW-1:0]       stall_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [7:0] LfsrSeed = 8'hA5;

    state_e        state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;   // words not yet issued
    logic [DW-1:0] next_data_q, next_data_d;
    logic [DW-1:0] step_q, step_d;
    logic [3:0]    mask_q, mask_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] sent_q, sent_d;
    logic [CW-1:0] stall_q, stall_d;

    logic handshake;
    logic gate_ok;
    logic lfsr_fb;

    assign handshake = valid_q & strm.o_ready;
    assign gate_ok   = ((lfsr_q[3:0] & mask_q) == 4'd0);
    // x^8 + x^6 + x^5 + x^4 + 1
    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        next_data_d = next_data_q;
        step_d      = step_q;
        mask_d      = mask_q;
        lfsr_d      = lfsr_q;
        valid_d     = valid_q;
        data_d      = data_q;
        sent_d      = sent_q;
        stall_d     = stall_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    remaining_d = cfg_count;
                    next_data_d = cfg_base;
                    step_d      = cfg_step;
                    mask_d      = cfg_gap_mask;
                    lfsr_d      = LfsrSeed;
                    sent_d      = '0;
                    stall_d     = '0;
                    state_d     = (cfg_count != '0) ? StRun : StDone;
                end
            end

            StRun: begin
                lfsr_d = {lfsr_q[6:0], lfsr_fb};

                if (handshake) begin
                    sent_d = sent_q + 1'b1;
                end
                if (valid_q && !strm.o_ready && (stall_q != '1)) begin
                    stall_d = stall_q + 1'b1;
                end

                // A new word may only be presented when the slot is empty or
                // being drained this cycle; otherwise the current word holds.
                if ((!valid_q || handshake) && (remaining_q != '0) && gate_ok) begin
                    valid_d     = 1'b1;
                    data_d      = next_data_q;
                    next_data_d = next_data_q + step_q;
                    remaining_d = remaining_q - 1'b1;
                end else if (handshake) begin
                    valid_d = 1'b0;
                end

                // Only one word is ever in flight, so a handshake with nothing
                // left to issue is the final one.
                if (handshake && (remaining_q == '0)) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            next_data_q <= '0;
            step_q      <= '0;
            mask_q      <= '0;
            lfsr_q      <= LfsrSeed;
            valid_q     <= 1'b0;
            data_q      <= '0;
            sent_q      <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            next_data_q <= next_data_d;
            step_q      <= step_d;
            mask_q      <= mask_d;
            lfsr_q      <= lfsr_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            sent_q      <= sent_d;
            stall_q     <= stall_d;
        end
    end

    assign strm.o_valid = valid_q;
    assign strm.o_data  = data_q;
    assign busy         = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign sent_count   = sent_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_elastic_stream_src.sv
// Self-checking bench for elastic_stream_src. A job-level model (queue of
// expected words, expected busy/done/counter values) is checked every cycle,
// and directed tests pin the model with literal expectations.
module tb_elastic_stream_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [15:0] cfg_count;
    logic [31:0] cfg_base;
    logic [31:0] cfg_step;
    logic [3:0]  cfg_gap_mask;
    logic        busy;
    logic        done;
    logic [15:0] sent_count;
    logic [15:0] stall_count;

    elastic_stream_src_if #(.DW(32)) sif ();

    elastic_stream_src #(.DW(32), .CW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_count    (cfg_count),
        .cfg_base     (cfg_base),
        .cfg_step     (cfg_step),
        .cfg_gap_mask (cfg_gap_mask),
        .strm         (sif),
        .busy         (busy),
        .done         (done),
        .sent_count   (sent_count),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [31:0] exp_q[$];
    logic [31:0] hs_data[$];
    int          hs_cyc[$];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_sent = '0;
    logic [15:0] m_stall = '0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pd = '0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          act_done_cyc = -1;
    int          done_pulses = 0;
    int          gap_cnt = 0;
    logic        job_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the job model; runs at the falling edge.
    task model_tick();
        logic        acc;
        logic        hs;
        logic        fin;
        logic [31:0] v;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_sent  = '0;
            m_stall = '0;
            pv      = 1'b0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("sent_count", sent_count, m_sent);
            chk("stall_count", stall_count, m_stall);
            if (!m_busy) chk("valid_outside_run", sif.o_valid, 0);
            if (pv && !pr) begin
                chk("hold_valid", sif.o_valid, 1);
                chk("hold_data", sif.o_data, pd);
            end
            if (done) begin
                act_done_cyc = cyc;
                done_pulses++;
            end
            if (m_done) job_done = 1'b1;
            if (m_busy && !sif.o_valid) gap_cnt++;

            hs  = sif.o_valid && sif.o_ready;
            acc = cfg_start && !m_busy && !m_done;
            fin = 1'b0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", sif.o_valid, 0);
                end else begin
                    chk("word", sif.o_data, exp_q.pop_front());
                    fin = (exp_q.size() == 0);
                end
                hs_data.push_back(sif.o_data);
                hs_cyc.push_back(cyc);
                m_sent++;
            end
            if (sif.o_valid && !sif.o_ready && (m_stall != 16'hFFFF)) m_stall++;

            m_done = 1'b0;
            if (acc) begin
                exp_q.delete();
                v = cfg_base;
                for (int i = 0; i < int'(cfg_count); i++) begin
                    exp_q.push_back(v);
                    v = v + cfg_step;
                end
                m_sent = '0;
                m_stall = '0;
                start_cyc = cyc;
                hs_data.delete();
                hs_cyc.delete();
                gap_cnt = 0;
                job_done = 1'b0;
                done_pulses = 0;
                act_done_cyc = -1;
                if (cfg_count == 0) m_done = 1'b1;
                else m_busy = 1'b1;
            end
            if (fin) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
            pv = sif.o_valid;
            pr = sif.o_ready;
            pd = sif.o_data;
        end
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the rising edge.
    task step();
        @(negedge clk);
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task start_job(input logic [15:0] n, input logic [31:0] base, input logic [31:0] stp,
                   input logic [3:0] mask);
        cfg_count    = n;
        cfg_base     = base;
        cfg_step     = stp;
        cfg_gap_mask = mask;
        cfg_start    = 1'b1;
        step();
        cfg_start    = 1'b0;
    endtask

    task wait_done(input int bound, input bit rnd);
        for (int n = 0; n < bound && !job_done; n++) begin
            if (rnd) sif.o_ready = 1'($urandom_range(0, 1));
            step();
        end
        chk("job_timeout", job_done, 1);
        sif.o_ready = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        cfg_start    = 1'b0;
        cfg_count    = '0;
        cfg_base     = '0;
        cfg_step     = '0;
        cfg_gap_mask = '0;
        sif.o_ready  = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", sif.o_valid, 0);
        chk("rst_data", sif.o_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_stall", stall_count, 0);
        step();

        // Full-rate job of three words
        start_job(16'd3, 32'h10, 32'd4, 4'h0);
        wait_done(50, 1'b0);
        chk("t1_n", hs_data.size(), 3);
        chk("t1_d0", hs_data[0], 32'h10);
        chk("t1_d1", hs_data[1], 32'h14);
        chk("t1_d2", hs_data[2], 32'h18);
        chk("t1_lat", hs_cyc[0] - start_cyc, 2);
        chk("t1_b2b1", hs_cyc[1] - hs_cyc[0], 1);
        chk("t1_b2b2", hs_cyc[2] - hs_cyc[1], 1);
        chk("t1_done", act_done_cyc - hs_cyc[2], 1);
        chk("t1_pulses", done_pulses, 1);
        chk("t1_sent", sent_count, 3);
        step();

        // Backpressure for five cycles on the first word
        sif.o_ready = 1'b0;
        start_job(16'd2, 32'h100, 32'd1, 4'h0);
        for (int n = 0; n < 20 && !sif.o_valid; n++) step();
        chk("t2_first_valid", sif.o_valid, 1);
        repeat (5) begin
            chk("t2_hold", sif.o_data, 32'h100);
            step();
        end
        sif.o_ready = 1'b1;
        wait_done(50, 1'b0);
        chk("t2_stall", stall_count, 5);
        chk("t2_sent", sent_count, 2);
        chk("t2_d0", hs_data[0], 32'h100);
        chk("t2_d1", hs_data[1], 32'h101);
        step();

        // Payload wrap-around; a mid-job start request must be ignored
        start_job(16'd4, 32'hFFFF_FFFE, 32'd1, 4'h0);
        step();
        cfg_count = 16'd9;
        cfg_base  = 32'h5555;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        wait_done(50, 1'b0);
        chk("t3_n", hs_data.size(), 4);
        chk("t3_d0", hs_data[0], 32'hFFFF_FFFE);
        chk("t3_d1", hs_data[1], 32'hFFFF_FFFF);
        chk("t3_d2", hs_data[2], 32'h0);
        chk("t3_d3", hs_data[3], 32'h1);
        step();

        // Zero-length job
        start_job(16'd0, 32'h77, 32'd1, 4'h0);
        wait_done(10, 1'b0);
        chk("t4_n", hs_data.size(), 0);
        chk("t4_done", act_done_cyc - start_cyc, 1);
        chk("t4_sent", sent_count, 0);
        step();

        // Fully throttled job with random ready
        start_job(16'd16, 32'h0, 32'd1, 4'hF);
        wait_done(8000, 1'b1);
        chk("t5_n", hs_data.size(), 16);
        for (int i = 0; i < 16; i++) chk("t5_word", hs_data[i], 32'(i));
        chk("t5_gaps", gap_cnt > 16, 1);
        chk("t5_sent", sent_count, 16);
        step();

        // Reset in the middle of a job
        start_job(16'd8, 32'h200, 32'd1, 4'h0);
        for (int n = 0; n < 30 && m_sent < 3; n++) step();
        chk("t6_three", m_sent, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", sif.o_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        repeat (4) step();
        chk("t6_no_pulse", done_pulses, 0);
        start_job(16'd2, 32'h300, 32'd2, 4'h0);
        wait_done(50, 1'b0);
        chk("t6_n", hs_data.size(), 2);
        chk("t6_d0", hs_data[0], 32'h300);
        chk("t6_d1", hs_data[1], 32'h302);
        chk("t6_sent", sent_count, 2);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
